// File: rtl/spiral_gen_if.sv
// Point stream between spiral_gen and its consumer: one (x, y, seg, dir) per valid/ready handshake.
interface spiral_gen_if #(
  parameter int WIDTH = 32,
  parameter int SEGW  = 7
) ();
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [SEGW-1:0]  seg;
  logic [1:0]       dir;

  modport master (output out_valid, x, y, seg, dir, input out_ready);
  modport slave  (input out_valid, x, y, seg, dir, output out_ready);
endinterface

// File: rtl/spiral_gen.sv
// Square-spiral (x, y) generator with loadable origin, bounded run and valid/ready output.
// Define SPIRAL_GEN_WRAP_EN to restart at the origin after the last point instead of stopping in DONE.
module spiral_gen #(
  parameter int WIDTH    = 32,
  parameter int STEP     = 1,
  parameter int MAX_SEGS = 64,
  parameter int CW       = 0,
  parameter int SEGW     = $clog2(MAX_SEGS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     x0,
  input  logic [WIDTH-1:0]     y0,
  spiral_gen_if.master         bus,
  output logic                 busy,
  output logic                 done
);

  localparam int LENW = $clog2(MAX_SEGS / 2 + 2);
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [SEGW-1:0]  SEG_MAX = SEGW'(MAX_SEGS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] x_r, x_s, y_r, y_s;
  logic [WIDTH-1:0] org_x_r, org_x_s, org_y_r, org_y_s;
  logic [SEGW-1:0]  seg_r, seg_s;
  logic [1:0]       dir_r, dir_s;
  logic [LENW-1:0]  j_r, j_s, seg_len_r, seg_len_s;
  logic             valid_r, valid_s;
  logic             done_r, done_s;
  logic             busy_r, busy_s;
  logic             fire_s;

  assign fire_s = valid_r && bus.out_ready;

  // Next-state and next-point computation
  always_comb begin
    state_s   = state_r;
    x_s       = x_r;
    y_s       = y_r;
    org_x_s   = org_x_r;
    org_y_s   = org_y_r;
    seg_s     = seg_r;
    dir_s     = dir_r;
    j_s       = j_r;
    seg_len_s = seg_len_r;
    valid_s   = valid_r;
    done_s    = done_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          org_x_s   = x0;
          org_y_s   = y0;
          x_s       = x0;
          y_s       = y0;
          seg_s     = {SEGW{1'b0}};
          dir_s     = 2'd0;
          j_s       = {LENW{1'b0}};
          seg_len_s = LENW'(1);
          valid_s   = 1'b1;
          done_s    = 1'b0;
          state_s   = ST_RUN;
        end else begin
          state_s = state_r;
        end
      end
      ST_RUN: begin
        done_s = 1'b0;
        if (fire_s) begin
          if (seg_r == SEG_MAX) begin
`ifdef SPIRAL_GEN_WRAP_EN
            x_s       = org_x_r;
            y_s       = org_y_r;
            seg_s     = {SEGW{1'b0}};
            dir_s     = 2'd0;
            j_s       = {LENW{1'b0}};
            seg_len_s = LENW'(1);
            valid_s   = 1'b1;
            done_s    = 1'b1;
`else
            state_s = ST_DONE;
            valid_s = 1'b0;
            done_s  = 1'b1;
`endif
          end else begin
            // dir 1 is +y counter-clockwise and -y clockwise; dir 3 is the opposite
            case (dir_r)
              2'd0:    x_s = x_r + STEP_W;
              2'd1:    y_s = (CW != 0) ? (y_r - STEP_W) : (y_r + STEP_W);
              2'd2:    x_s = x_r - STEP_W;
              2'd3:    y_s = (CW != 0) ? (y_r + STEP_W) : (y_r - STEP_W);
              default: x_s = x_r;
            endcase
            if (j_r + LENW'(1) == seg_len_r) begin
              j_s   = {LENW{1'b0}};
              seg_s = seg_r + SEGW'(1);
              dir_s = dir_r + 2'd1;
              // lengths run 1,1,2,2,...: grow after every odd-indexed segment
              if (seg_r[0]) begin
                seg_len_s = seg_len_r + LENW'(1);
              end else begin
                seg_len_s = seg_len_r;
              end
            end else begin
              j_s = j_r + LENW'(1);
            end
          end
        end else begin
          valid_s = valid_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        valid_s = 1'b0;
        done_s  = 1'b0;
      end
    endcase
    busy_s = (state_s == ST_RUN);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      x_r       <= {WIDTH{1'b0}};
      y_r       <= {WIDTH{1'b0}};
      org_x_r   <= {WIDTH{1'b0}};
      org_y_r   <= {WIDTH{1'b0}};
      seg_r     <= {SEGW{1'b0}};
      dir_r     <= 2'd0;
      j_r       <= {LENW{1'b0}};
      seg_len_r <= LENW'(1);
      valid_r   <= 1'b0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      x_r       <= x_s;
      y_r       <= y_s;
      org_x_r   <= org_x_s;
      org_y_r   <= org_y_s;
      seg_r     <= seg_s;
      dir_r     <= dir_s;
      j_r       <= j_s;
      seg_len_r <= seg_len_s;
      valid_r   <= valid_s;
      done_r    <= done_s;
      busy_r    <= busy_s;
    end
  end

  assign bus.out_valid = valid_r;
  assign bus.x         = x_r;
  assign bus.y         = y_r;
  assign bus.seg       = seg_r;
  assign bus.dir       = dir_r;
  assign busy          = busy_r;
  assign done          = done_r;

endmodule

// File: tb/tb_spiral_gen.sv
// Directed bench for spiral_gen: three parameterisations, backpressure, reset and restart cases.
module tb_spiral_gen;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  logic        start0, start1, start2;
  logic [31:0] x0_0, y0_0, x0_1, y0_1;
  logic [7:0]  x0_2, y0_2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;

  spiral_gen_if #(.WIDTH(32), .SEGW(3)) if0 ();
  spiral_gen_if #(.WIDTH(32), .SEGW(2)) if1 ();
  spiral_gen_if #(.WIDTH(8),  .SEGW(1)) if2 ();

  spiral_gen #(.WIDTH(32), .STEP(1), .MAX_SEGS(4), .CW(0)) u0 (
    .clk(clk), .reset(reset), .start(start0), .x0(x0_0), .y0(y0_0),
    .bus(if0.master), .busy(busy0), .done(done0));

  spiral_gen #(.WIDTH(32), .STEP(3), .MAX_SEGS(2), .CW(1)) u1 (
    .clk(clk), .reset(reset), .start(start1), .x0(x0_1), .y0(y0_1),
    .bus(if1.master), .busy(busy1), .done(done1));

  spiral_gen #(.WIDTH(8), .STEP(1), .MAX_SEGS(1), .CW(0)) u2 (
    .clk(clk), .reset(reset), .start(start2), .x0(x0_2), .y0(y0_2),
    .bus(if2.master), .busy(busy2), .done(done2));

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference spiral for MAX_SEGS=4 from (0,0), counter-clockwise, step 1
  int ex0 [7] = '{0, 1, 1, 0, -1, -1, -1};
  int ey0 [7] = '{0, 0, 1, 1, 1, 0, -1};
  int es0 [7] = '{0, 1, 2, 2, 3, 3, 4};
  int ed0 [7] = '{0, 1, 2, 2, 3, 3, 0};
  int ex1 [3] = '{10, 13, 13};
  int ey1 [3] = '{-5, -5, -8};
  int es1 [3] = '{0, 1, 2};

  // Stimulus and checks
  initial begin
    int nreps;
    int idx;
    int cyc;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    x0_0 = 32'd0; y0_0 = 32'd0; x0_1 = 32'd0; y0_1 = 32'd0;
    x0_2 = 8'd0; y0_2 = 8'd0;
    if0.out_ready = 1'b0; if1.out_ready = 1'b0; if2.out_ready = 1'b0;
    tick;
    tick;
    chk("rst_valid", if0.out_valid, 0);
    chk("rst_x", $signed(if0.x), 0);
    chk("rst_y", $signed(if0.y), 0);
    chk("rst_seg", if0.seg, 0);
    chk("rst_dir", if0.dir, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    reset = 1'b0;

`ifdef SPIRAL_GEN_WRAP_EN
    nreps = 2;
`else
    nreps = 1;
`endif
    start0 = 1'b1;
    tick;
    start0 = 1'b0;
    if0.out_ready = 1'b1;
    for (int r = 0; r < nreps; r++) begin
      for (int i = 0; i < 7; i++) begin
        chk("run_valid", if0.out_valid, 1);
        chk("run_x", $signed(if0.x), ex0[i]);
        chk("run_y", $signed(if0.y), ey0[i]);
        chk("run_seg", if0.seg, es0[i]);
        chk("run_dir", if0.dir, ed0[i]);
        chk("run_busy", busy0, 1);
        chk("run_done", done0, (r > 0 && i == 0) ? 1 : 0);
        tick;
      end
    end
`ifdef SPIRAL_GEN_WRAP_EN
    chk("wrap_valid", if0.out_valid, 1);
    chk("wrap_x", $signed(if0.x), 0);
    chk("wrap_seg", if0.seg, 0);
    chk("wrap_done", done0, 1);
    chk("wrap_busy", busy0, 1);
`else
    chk("end_valid", if0.out_valid, 0);
    chk("end_done", done0, 1);
    chk("end_busy", busy0, 0);
    chk("end_x", $signed(if0.x), -1);
    chk("end_y", $signed(if0.y), -1);
    chk("end_seg", if0.seg, 4);
`endif
    if0.out_ready = 1'b0;

    // Mid-run start is ignored, mid-run reset clears, restart from (5,5)
    reset = 1'b1;
    tick;
    reset = 1'b0;
    start0 = 1'b1;
    tick;
    start0 = 1'b0;
    if0.out_ready = 1'b1;
    tick;
    start0 = 1'b1; x0_0 = 32'd99; y0_0 = 32'd99;
    tick;
    start0 = 1'b0;
    chk("ign_x", $signed(if0.x), 1);
    chk("ign_y", $signed(if0.y), 1);
    chk("ign_seg", if0.seg, 2);
    tick;
    chk("p3_x", $signed(if0.x), 0);
    chk("p3_y", $signed(if0.y), 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    if0.out_ready = 1'b0;
    chk("mrst_valid", if0.out_valid, 0);
    chk("mrst_x", $signed(if0.x), 0);
    chk("mrst_y", $signed(if0.y), 0);
    chk("mrst_seg", if0.seg, 0);
    chk("mrst_busy", busy0, 0);
    x0_0 = 32'd5; y0_0 = 32'd5; start0 = 1'b1;
    tick;
    start0 = 1'b0;
    chk("rs_valid", if0.out_valid, 1);
    chk("rs_x", $signed(if0.x), 5);
    chk("rs_y", $signed(if0.y), 5);
    chk("rs_seg", if0.seg, 0);
    chk("rs_busy", busy0, 1);
    reset = 1'b1; start0 = 1'b1;
    tick;
    reset = 1'b0; start0 = 1'b0;
    chk("rstart_valid", if0.out_valid, 0);
    chk("rstart_busy", busy0, 0);

    // Backpressure: ready pattern 1,0,0 repeating
    x0_0 = 32'd0; y0_0 = 32'd0; start0 = 1'b1;
    tick;
    start0 = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 7 && cyc < 60) begin
      if0.out_ready = (cyc % 3 == 0);
      chk("bp_valid", if0.out_valid, 1);
      chk("bp_x", $signed(if0.x), ex0[idx]);
      chk("bp_y", $signed(if0.y), ey0[idx]);
      chk("bp_seg", if0.seg, es0[idx]);
      tick;
      if (if0.out_ready) idx++;
      cyc++;
    end
    chk("bp_count", idx, 7);
`ifdef SPIRAL_GEN_WRAP_EN
    chk("bp_wrap_valid", if0.out_valid, 1);
    chk("bp_wrap_x", $signed(if0.x), 0);
`else
    chk("bp_end_valid", if0.out_valid, 0);
    chk("bp_end_done", done0, 1);
`endif
    if0.out_ready = 1'b0;

    // Clockwise, step 3, two segments
    x0_1 = 32'd10; y0_1 = -32'sd5; start1 = 1'b1;
    tick;
    start1 = 1'b0;
    if1.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("cw_valid", if1.out_valid, 1);
      chk("cw_x", $signed(if1.x), ex1[i]);
      chk("cw_y", $signed(if1.y), ey1[i]);
      chk("cw_seg", if1.seg, es1[i]);
      tick;
    end
`ifdef SPIRAL_GEN_WRAP_EN
    chk("cw_wrap_valid", if1.out_valid, 1);
    chk("cw_wrap_x", $signed(if1.x), 10);
    chk("cw_wrap_done", done1, 1);
`else
    chk("cw_end_valid", if1.out_valid, 0);
    chk("cw_end_done", done1, 1);
`endif
    if1.out_ready = 1'b0;

    // 8-bit coordinate wrap at +127
    x0_2 = 8'd127; y0_2 = 8'd0; start2 = 1'b1;
    tick;
    start2 = 1'b0;
    if2.out_ready = 1'b1;
    chk("w8_x0", $signed(if2.x), 127);
    chk("w8_seg0", if2.seg, 0);
    tick;
    chk("w8_x1", $signed(if2.x), -128);
    chk("w8_y1", $signed(if2.y), 0);
    chk("w8_seg1", if2.seg, 1);
    chk("w8_done1", done2, 0);
    tick;
`ifdef SPIRAL_GEN_WRAP_EN
    chk("w8_wrap_valid", if2.out_valid, 1);
    chk("w8_wrap_x", $signed(if2.x), 127);
    chk("w8_wrap_done", done2, 1);
`else
    chk("w8_end_valid", if2.out_valid, 0);
    chk("w8_end_done", done2, 1);
    chk("w8_end_x", $signed(if2.x), -128);
`endif
    if2.out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
